// File: rtl/wbs_burst_ram_if.sv
// rtl/wbs_burst_ram_if.sv - Wishbone B4 slave bus bundle for wbs_burst_ram (wbs_err_o only with WBS_ERR_EN)
interface wbs_burst_ram_if;
   logic [31:0] wbs_dat_i;
   logic [31:2] wbs_adr_i;
   logic [3:0]  wbs_sel_i;
   logic [1:0]  wbs_bte_i;
   logic [2:0]  wbs_cti_i;
   logic        wbs_we_i;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
`ifdef WBS_ERR_EN
   logic        wbs_err_o;

   modport master (
      output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
             wbs_we_i, wbs_cyc_i, wbs_stb_i,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o
   );
   modport slave (
      input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
             wbs_we_i, wbs_cyc_i, wbs_stb_i,
      output wbs_dat_o, wbs_ack_o, wbs_err_o
   );
`else
   modport master (
      output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
             wbs_we_i, wbs_cyc_i, wbs_stb_i,
      input  wbs_dat_o, wbs_ack_o
   );
   modport slave (
      input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
             wbs_we_i, wbs_cyc_i, wbs_stb_i,
      output wbs_dat_o, wbs_ack_o
   );
`endif
endinterface

// File: rtl/wbs_burst_ram.sv
// rtl/wbs_burst_ram.sv - Wishbone slave RAM with classic and linear/wrap burst cycles
// Optional WBS_ERR_EN: out-of-range addresses answer with wbs_err_o instead of aliasing.
module wbs_burst_ram #(
   parameter int mem_adr_width = 8
) (
   input  logic            wbs_clk,
   input  logic            wbs_rst,
   wbs_burst_ram_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

   localparam logic [mem_adr_width-1:0] ADR_ONE = 1;

   state_t                   state, state_nxt;
   logic [31:0]              mem [2**mem_adr_width];
   logic [mem_adr_width-1:0] adr_q;
   logic [mem_adr_width-1:0] adr_nxt;
   logic [mem_adr_width-1:0] wrap_mask;
   logic [mem_adr_width-1:0] req_adr;
   logic [31:0]              dat_q;
   logic                     err_q;
   logic                     oor;
   logic                     req;
   logic                     beat;
   logic                     adv;
   logic                     wr_en;

`ifdef WBS_ERR_EN
   assign oor = |bus.wbs_adr_i[31:mem_adr_width+2];
   assign bus.wbs_err_o = beat & err_q;
`else
   logic unused_adr_hi;
   assign oor = 1'b0;
   assign unused_adr_hi = ^bus.wbs_adr_i[31:mem_adr_width+2];
`endif

   assign req     = bus.wbs_cyc_i & bus.wbs_stb_i;
   assign req_adr = bus.wbs_adr_i[mem_adr_width+1:2];
   // Classic ack lasts the single CLASSIC cycle; burst ack follows stb & cyc live.
   assign beat    = (state != IDLE) & req;
   assign adv     = (state == BURST) & beat;
   assign wr_en   = beat & bus.wbs_we_i & ~err_q;

   assign bus.wbs_ack_o = beat & ~err_q;
   assign bus.wbs_dat_o = dat_q;

   always_comb begin
      wrap_mask = '1;
      case (bus.wbs_bte_i)
         2'b01:   wrap_mask = mem_adr_width'(3);
         2'b10:   wrap_mask = mem_adr_width'(7);
         2'b11:   wrap_mask = mem_adr_width'(15);
         default: wrap_mask = '1;
      endcase
      adr_nxt = (adr_q & ~wrap_mask) | ((adr_q + ADR_ONE) & wrap_mask);
   end

   always_ff @(posedge wbs_clk or posedge wbs_rst) begin
      if (wbs_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) state_nxt = (bus.wbs_cti_i == 3'b010) ? BURST : CLASSIC;
         end
         CLASSIC: state_nxt = IDLE;
         BURST: begin
            if (!bus.wbs_cyc_i)                         state_nxt = IDLE;
            else if (beat && bus.wbs_cti_i == 3'b111)   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read data is prefetched from the next address so burst beats need no bubble.
   always_ff @(posedge wbs_clk or posedge wbs_rst) begin
      if (wbs_rst) begin
         adr_q <= '0;
         dat_q <= '0;
         err_q <= 1'b0;
      end else if (state == IDLE && req) begin
         adr_q <= req_adr;
         err_q <= oor;
         dat_q <= oor ? 32'h0 : mem[req_adr];
      end else if (adv) begin
         adr_q <= adr_nxt;
         dat_q <= err_q ? 32'h0 : mem[adr_nxt];
      end
   end

   always_ff @(posedge wbs_clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wbs_sel_i[b]) mem[adr_q][8*b +: 8] <= bus.wbs_dat_i[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_wbs_burst_ram.sv
// tb/tb_wbs_burst_ram.sv - directed self-checking bench for wbs_burst_ram
module tb_wbs_burst_ram;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [31:0] rd;

   wbs_burst_ram_if bus ();

   wbs_burst_ram #(.mem_adr_width(8)) dut (
      .wbs_clk (clk),
      .wbs_rst (rst),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_cti_i = 3'b000;
      bus.wbs_bte_i = 2'b00;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_dat_i = 32'h0;
      bus.wbs_adr_i = 30'h0;
   endtask

   task automatic drive(input logic we, input logic [29:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      bus.wbs_sel_i = sel;
      bus.wbs_cti_i = cti;
      bus.wbs_bte_i = bte;
   endtask

   task automatic classic(input string tag, input logic we, input logic [29:0] adr,
                          input logic [31:0] wdat, input logic [3:0] sel, output logic [31:0] rdat);
      drive(we, adr, wdat, sel, 3'b000, 2'b00);
      #1 check_eq({tag, "_ack_pre"}, {31'h0, bus.wbs_ack_o}, 32'h0);
      @(posedge clk); #1;
      check_eq({tag, "_ack"}, {31'h0, bus.wbs_ack_o}, 32'h1);
      rdat = bus.wbs_dat_o;
      @(posedge clk); #1;
      check_eq({tag, "_ack_post"}, {31'h0, bus.wbs_ack_o}, 32'h0);
      idle_bus();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle_bus();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check_eq("rst_dat", bus.wbs_dat_o, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      classic("c_wr5", 1'b1, 30'd5, 32'hDEADBEEF, 4'hF, rd);
      classic("c_rd5", 1'b0, 30'd5, 32'h0, 4'h0, rd);
      check_eq("c_rd5_dat", rd, 32'hDEADBEEF);

      classic("be_wr_a", 1'b1, 30'd5, 32'h11223344, 4'hF, rd);
      classic("be_wr_b", 1'b1, 30'd5, 32'hAABBCCDD, 4'b0101, rd);
      classic("be_rd", 1'b0, 30'd5, 32'h0, 4'h0, rd);
      check_eq("be_rd_dat", rd, 32'h11BB33DD);

      for (int n = 0; n < 16; n++) classic("preload", 1'b1, 30'(n), 32'(n), 4'hF, rd);

      // wrap4 read from word 6: expect 6,7,4,5
      drive(1'b0, 30'd6, 32'h0, 4'h0, 3'b010, 2'b01);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] exp_w4 [4];
         exp_w4 = '{32'd6, 32'd7, 32'd4, 32'd5};
         @(posedge clk); #1;
         check_eq($sformatf("w4_ack%0d", i), {31'h0, bus.wbs_ack_o}, 32'h1);
         check_eq($sformatf("w4_dat%0d", i), bus.wbs_dat_o, exp_w4[i]);
         if (i == 3) bus.wbs_cti_i = 3'b111;
      end
      @(posedge clk); #1;
      check_eq("w4_ack_end", {31'h0, bus.wbs_ack_o}, 32'h0);
      idle_bus();
      @(posedge clk); #1;

      // linear write burst at 254 with a two-cycle stb gap before the last beat
      drive(1'b1, 30'd254, 32'hA0, 4'hF, 3'b010, 2'b00);
      @(posedge clk); #1;
      check_eq("lin_ack0", {31'h0, bus.wbs_ack_o}, 32'h1);
      @(posedge clk); #1;
      bus.wbs_dat_i = 32'hA1;
      check_eq("lin_ack1", {31'h0, bus.wbs_ack_o}, 32'h1);
      @(posedge clk); #1;
      bus.wbs_stb_i = 1'b0;
      #1 check_eq("lin_gap0", {31'h0, bus.wbs_ack_o}, 32'h0);
      @(posedge clk); #1;
      check_eq("lin_gap1", {31'h0, bus.wbs_ack_o}, 32'h0);
      @(posedge clk); #1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_dat_i = 32'hA2;
      bus.wbs_cti_i = 3'b111;
      #1 check_eq("lin_ack2", {31'h0, bus.wbs_ack_o}, 32'h1);
      @(posedge clk); #1;
      check_eq("lin_ack_end", {31'h0, bus.wbs_ack_o}, 32'h0);
      idle_bus();
      @(posedge clk); #1;
      classic("lin_rd254", 1'b0, 30'd254, 32'h0, 4'h0, rd);
      check_eq("lin_rd254_dat", rd, 32'hA0);
      classic("lin_rd255", 1'b0, 30'd255, 32'h0, 4'h0, rd);
      check_eq("lin_rd255_dat", rd, 32'hA1);
      classic("lin_rd0", 1'b0, 30'd0, 32'h0, 4'h0, rd);
      check_eq("lin_rd0_dat", rd, 32'hA2);
      classic("lin_rd1", 1'b0, 30'd1, 32'h0, 4'h0, rd);
      check_eq("lin_rd1_dat", rd, 32'h1);

      // wrap8 read from word 10, reset during beat 2
      drive(1'b0, 30'd10, 32'h0, 4'h0, 3'b010, 2'b10);
      @(posedge clk); #1;
      check_eq("w8_dat0", bus.wbs_dat_o, 32'd10);
      @(posedge clk); #1;
      check_eq("w8_ack1", {31'h0, bus.wbs_ack_o}, 32'h1);
      check_eq("w8_dat1", bus.wbs_dat_o, 32'd11);
      rst = 1'b1;
      #1;
      check_eq("w8_rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check_eq("w8_rst_dat", bus.wbs_dat_o, 32'h0);
      idle_bus();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      classic("w8_after", 1'b0, 30'd12, 32'h0, 4'h0, rd);
      check_eq("w8_after_dat", rd, 32'd12);

      // word address 0x100 lies above the 8-bit memory range
`ifdef WBS_ERR_EN
      drive(1'b0, 30'h100, 32'h0, 4'h0, 3'b000, 2'b00);
      @(posedge clk); #1;
      check_eq("oor_err", {31'h0, bus.wbs_err_o}, 32'h1);
      check_eq("oor_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check_eq("oor_dat", bus.wbs_dat_o, 32'h0);
      @(posedge clk); #1;
      check_eq("oor_err_end", {31'h0, bus.wbs_err_o}, 32'h0);
      idle_bus();
      @(posedge clk); #1;
`else
      classic("alias", 1'b0, 30'h100, 32'h0, 4'h0, rd);
      check_eq("alias_dat", rd, 32'hA2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
